// File: rtl/waveform_readout_controller.sv
// Trigger-driven waveform readout: arms on trigger, waits out capture,
// then streams a 4-byte header and 2 bytes per sample to a UART.
module waveform_readout_controller #(
    parameter int NSAMPLES = 500,
    parameter int HOLDOFF  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigIn,
    input  logic        armEn,
    output logic        trigOut,
    output logic [8:0]  sampleAddr,
    input  logic [13:0] sampleData,
    input  logic [15:0] waveNumber,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        busy,
    output logic [7:0]  dropCount
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_HEADER  = 3'd2;
    localparam logic [2:0] S_SAMPLES = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    localparam logic [9:0] CAP_LAST  = 10'(NSAMPLES + 1);
    localparam logic [9:0] HOLD_LAST = 10'(HOLDOFF - 1);
    localparam logic [8:0] ADDR_LAST = 9'(NSAMPLES - 1);

    logic [2:0]  state;
    logic [9:0]  cnt;
    logic [8:0]  addr;
    logic        half;
    logic [15:0] wnum;
    logic        trig_q;
    logic        xfer;
    logic        trig_rise;
    logic        accept;

    assign txValid    = (state == S_HEADER) || (state == S_SAMPLES);
    assign xfer       = txValid && txReady;
    assign busy       = (state != S_IDLE);
    assign sampleAddr = (state == S_SAMPLES) ? addr : 9'd0;
    assign trig_rise  = trigIn && !trig_q;
    assign accept     = (state == S_IDLE) && trigIn && armEn;

    // Byte mux is held by state/index regs, so it stays stable under stall.
    always_comb begin
        txData = 8'h00;
        case (state)
            S_HEADER: begin
                case (cnt[1:0])
                    2'd0:    txData = 8'hA5;
                    2'd1:    txData = 8'h5A;
                    2'd2:    txData = wnum[15:8];
                    default: txData = wnum[7:0];
                endcase
            end
            S_SAMPLES: begin
                txData = half ? sampleData[7:0] : {2'b00, sampleData[13:8]};
            end
            default: txData = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 10'd0;
            addr      <= 9'd0;
            half      <= 1'b0;
            wnum      <= 16'd0;
            trig_q    <= 1'b0;
            trigOut   <= 1'b0;
            dropCount <= 8'd0;
        end else begin
            trig_q  <= trigIn;
            trigOut <= accept;
            if (busy && trig_rise && dropCount != 8'hFF) begin
                dropCount <= dropCount + 8'd1;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_CAPTURE;
                        cnt   <= 10'd0;
                    end
                end
                S_CAPTURE: begin
                    if (cnt == CAP_LAST) begin
                        state <= S_HEADER;
                        cnt   <= 10'd0;
                        wnum  <= waveNumber;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                S_HEADER: begin
                    if (xfer) begin
                        if (cnt[1:0] == 2'd3) begin
                            state <= S_SAMPLES;
                            cnt   <= 10'd0;
                            addr  <= 9'd0;
                            half  <= 1'b0;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                end
                S_SAMPLES: begin
                    if (xfer) begin
                        half <= !half;
                        if (half) begin
                            if (addr == ADDR_LAST) begin
                                state <= S_HOLDOFF;
                                addr  <= 9'd0;
                                cnt   <= 10'd0;
                            end else begin
                                addr <= addr + 9'd1;
                            end
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        state <= S_IDLE;
                        cnt   <= 10'd0;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
